// File: rtl/alu_sequencer.sv
// Sequencer around an external combinational ALU with a 4x4-bit register file.
// Each command is accepted in IDLE, runs through ISSUE (ALU ops only) and WRITE,
// and is held in RESP until the consumer takes the result.
module alu_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_rd,
  input  logic [1:0] cmd_rs,
  input  logic [1:0] cmd_rt,
  input  logic [3:0] cmd_imm,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_s,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic [1:0] res_rd
);

  typedef enum logic [1:0] {IDLE, ISSUE, WRITE, RESP} state_e;

  state_e          state_q, state_d;
  logic [3:0][3:0] regs_q, regs_d;
  logic [3:0]      alu_a_q, alu_a_d;
  logic [3:0]      alu_b_q, alu_b_d;
  logic [2:0]      alu_op_q, alu_op_d;
  logic [1:0]      rd_q, rd_d;
  logic [3:0]      imm_q, imm_d;
  logic            load_q, load_d;
  logic [3:0]      res_data_q, res_data_d;
  logic [1:0]      res_rd_q, res_rd_d;
  logic [3:0]      wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      regs_q     <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      load_q     <= 1'b0;
      res_data_q <= '0;
      res_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      regs_q     <= regs_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      rd_q       <= rd_d;
      imm_q      <= imm_d;
      load_q     <= load_d;
      res_data_q <= res_data_d;
      res_rd_q   <= res_rd_d;
    end
  end

  // Operands are captured from the register file at accept, so rd==rs/rt
  // always sees the pre-write value; the register file is only written in WRITE.
  always_comb begin
    state_d    = state_q;
    regs_d     = regs_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    rd_d       = rd_q;
    imm_d      = imm_q;
    load_d     = load_q;
    res_data_d = res_data_q;
    res_rd_d   = res_rd_q;
    wdata      = load_q ? imm_q : alu_s;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          rd_d   = cmd_rd;
          load_d = cmd_load;
          if (cmd_load) begin
            imm_d   = cmd_imm;
            state_d = WRITE;
          end else begin
            alu_a_d  = regs_q[cmd_rs];
            alu_b_d  = regs_q[cmd_rt];
            alu_op_d = cmd_op;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: state_d = WRITE;
      WRITE: begin
        regs_d[rd_q] = wdata;
        res_data_d   = wdata;
        res_rd_d     = rd_q;
        state_d      = RESP;
      end
      RESP: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign res_valid = (state_q == RESP);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign res_data  = res_data_q;
  assign res_rd    = res_rd_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a reference ALU attached.
// Stimulus pushes hand-computed expected results; a monitor pops and checks them.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [2:0] cmd_op;
  logic [1:0] cmd_rd, cmd_rs, cmd_rt;
  logic [3:0] cmd_imm;
  logic [3:0] alu_a, alu_b, alu_s;
  logic [2:0] alu_op;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [1:0] res_rd;

  typedef struct {
    logic [3:0] data;
    logic [1:0] rd;
    int         lat;
  } exp_t;

  exp_t       expQ[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         compCount = 0;
  int         cyc = 0;
  int         acceptCyc = 0;
  int         done = 0;
  bit         inResp = 1'b0;
  logic [3:0] heldData;
  logic [1:0] heldRd;

  alu_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_load  (cmd_load),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_rs    (cmd_rs),
    .cmd_rt    (cmd_rt),
    .cmd_imm   (cmd_imm),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_s     (alu_s),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_rd    (res_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU; sign-of-difference returns the sign bit of a-b in bit 0.
  function automatic logic [3:0] refAlu(input logic [3:0] a, b, input logic [2:0] op);
    logic [3:0] d;
    d = a - b;
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b100:  return a & ~b;
      3'b101:  return a | ~b;
      3'b110:  return d;
      default: return {3'b000, d[3]};
    endcase
  endfunction

  always_comb alu_s = refAlu(alu_a, alu_b, alu_op);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per response, then checks it stays stable until taken.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      checkOutput("resValidInReset", {31'd0, res_valid}, 32'd0);
      inResp = 1'b0;
    end else if (res_valid) begin
      if (!inResp) begin
        inResp   = 1'b1;
        heldData = res_data;
        heldRd   = res_rd;
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpectedResp: got data %0h rd %0d, expected no response", res_data, res_rd);
        end else begin
          e = expQ.pop_front();
          checkOutput("resData", {28'd0, res_data}, {28'd0, e.data});
          checkOutput("resRd", {30'd0, res_rd}, {30'd0, e.rd});
          checkOutput("latency", cyc - acceptCyc + 1, e.lat);
        end
      end else begin
        checkOutput("resDataStable", {28'd0, res_data}, {28'd0, heldData});
        checkOutput("resRdStable", {30'd0, res_rd}, {30'd0, heldRd});
      end
      if (res_ready) begin
        compCount++;
        inResp = 1'b0;
      end
    end else begin
      inResp = 1'b0;
    end
  end

  task automatic applyStimulus(input logic ld, input logic [2:0] op, input logic [1:0] rd, rs, rt,
                               input logic [3:0] imm, expA, expB, expData, input bit push);
    int   waitCnt;
    exp_t e;
    waitCnt = 0;
    @(negedge clk);
    while (!cmd_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!cmd_ready) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL cmdReadyTimeout: got cmd_ready 0, expected 1");
      return;
    end
    cmd_valid = 1'b1;
    cmd_load  = ld;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs    = rs;
    cmd_rt    = rt;
    cmd_imm   = imm;
    if (push) begin
      e.data = expData;
      e.rd   = rd;
      e.lat  = ld ? 2 : 3;
      expQ.push_back(e);
    end
    @(posedge clk);
    #1 acceptCyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (!ld) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput("aluA", {28'd0, alu_a}, {28'd0, expA});
        checkOutput("aluB", {28'd0, alu_b}, {28'd0, expB});
        checkOutput("aluOp", {29'd0, alu_op}, {29'd0, op});
        if (i == 0) @(negedge clk);
      end
    end
  endtask

  task automatic waitComplete(input int n);
    int k;
    k = 0;
    while (compCount < n && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (compCount < n) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL completionTimeout: got %0d completions, expected %0d", compCount, n);
    end
  endtask

  task automatic runCmd(input logic ld, input logic [2:0] op, input logic [1:0] rd, rs, rt,
                        input logic [3:0] imm, expA, expB, expData);
    applyStimulus(ld, op, rd, rs, rt, imm, expA, expB, expData, 1'b1);
    done++;
    waitComplete(done);
  endtask

  task automatic checkResetOutputs();
    checkOutput("aluAReset", {28'd0, alu_a}, 32'd0);
    checkOutput("aluBReset", {28'd0, alu_b}, 32'd0);
    checkOutput("aluOpReset", {29'd0, alu_op}, 32'd0);
    checkOutput("resDataReset", {28'd0, res_data}, 32'd0);
    checkOutput("resRdReset", {30'd0, res_rd}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_load  = 1'b0;
    cmd_op    = 3'b000;
    cmd_rd    = 2'd0;
    cmd_rs    = 2'd0;
    cmd_rt    = 2'd0;
    cmd_imm   = 4'd0;
    res_ready = 1'b1;

    repeat (2) begin
      @(negedge clk);
      checkResetOutputs();
    end
    rst_n = 1'b1;
    #1 checkOutput("cmdReadyAfterReset", {31'd0, cmd_ready}, 32'd1);

    runCmd(1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 4'd5,  4'd0, 4'd0, 4'd5);
    runCmd(1'b1, 3'b000, 2'd2, 2'd0, 2'd0, 4'd3,  4'd0, 4'd0, 4'd3);
    runCmd(1'b0, 3'b010, 2'd3, 2'd1, 2'd2, 4'd0,  4'd5, 4'd3, 4'd8);
    runCmd(1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 4'd9,  4'd0, 4'd0, 4'd9);
    runCmd(1'b0, 3'b110, 2'd0, 2'd0, 2'd0, 4'd0,  4'd9, 4'd9, 4'd0);

    // Hold the result while hammering cmd_valid; nothing may be queued.
    res_ready = 1'b0;
    applyStimulus(1'b0, 3'b001, 2'd1, 2'd1, 2'd2, 4'd0, 4'd5, 4'd3, 4'd7, 1'b1);
    done++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("cmdReadyHeld", {31'd0, cmd_ready}, 32'd0);
      checkOutput("resValidHeld", {31'd0, res_valid}, 32'd1);
      cmd_valid = i[0];
      cmd_load  = 1'b1;
      cmd_rd    = 2'd1;
      cmd_imm   = 4'hA;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    waitComplete(done);
    repeat (6) @(negedge clk);
    checkOutput("singleCompletion", compCount, done);

    runCmd(1'b1, 3'b000, 2'd2, 2'd0, 2'd0, 4'd15, 4'd0,  4'd0,  4'd15);
    runCmd(1'b0, 3'b010, 2'd2, 2'd2, 2'd2, 4'd0,  4'd15, 4'd15, 4'd14);

    // Abort an ADD in WRITE; R3 must still read back as zero afterwards.
    applyStimulus(1'b0, 3'b010, 2'd3, 2'd1, 2'd2, 4'd0, 4'd7, 4'd14, 4'd5, 1'b0);
    rst_n = 1'b0;
    #1 checkOutput("resValidAsyncDrop", {31'd0, res_valid}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      checkResetOutputs();
    end
    rst_n = 1'b1;
    #1 checkOutput("cmdReadyAfterAbort", {31'd0, cmd_ready}, 32'd1);
    runCmd(1'b0, 3'b001, 2'd3, 2'd3, 2'd3, 4'd0, 4'd0, 4'd0, 4'd0);

    runCmd(1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 4'd12, 4'd0,  4'd0,  4'd12);
    runCmd(1'b1, 3'b000, 2'd2, 2'd0, 2'd0, 4'd10, 4'd0,  4'd0,  4'd10);
    runCmd(1'b0, 3'b100, 2'd0, 2'd1, 2'd2, 4'd0,  4'd12, 4'd10, 4'd4);
    runCmd(1'b0, 3'b101, 2'd3, 2'd1, 2'd2, 4'd0,  4'd12, 4'd10, 4'd13);
    runCmd(1'b0, 3'b000, 2'd0, 2'd1, 2'd2, 4'd0,  4'd12, 4'd10, 4'd8);

    repeat (5) @(negedge clk);
    checkOutput("totalCompletions", compCount, done);
    checkOutput("queueEmpty", expQ.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
